// File: rtl/trv_regfile_pkg.sv
// Shared register-file types and architectural constants for the TRV-32 datapath.
package trv_regfile_pkg;

    localparam int REG_COUNT_RV32I = 32;
    localparam int REG_COUNT_RV32E = 16;

    localparam int REG_X0 = 0;
    localparam int REG_SP = 2;

    typedef logic [4:0]  reg_addr_t;
    typedef logic [31:0] xlen_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy tracking: alloc marks a pending producer, writeback retires it.
module regfile_scoreboard #(
    parameter int REG_COUNT = 32,
    parameter int N_WR      = 1,
    parameter int AW        = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      alloc_en,
    input  logic [AW-1:0]             alloc_addr,
    input  logic [N_WR-1:0]           wr_en,
    input  logic [N_WR-1:0][AW-1:0]   wr_addr,
    output logic [REG_COUNT-1:0]      busy_vec
);

    logic [REG_COUNT-1:0] busy_q;
    logic [REG_COUNT-1:0] wb_hit;

    always_comb begin
        wb_hit = '0;
        for (int i = 0; i < N_WR; i++) begin
            for (int r = 0; r < REG_COUNT; r++) begin
                if (wr_en[i] && int'(wr_addr[i]) == r) wb_hit[r] = 1'b1;
            end
        end
    end

    // Bit 0 is only ever written by reset, so x0 never reports busy.
    // Alloc wins over a same-cycle writeback: the new producer is still pending.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            for (int r = 1; r < REG_COUNT; r++) begin
                if (alloc_en && int'(alloc_addr) == r) busy_q[r] <= 1'b1;
                else if (wb_hit[r])                    busy_q[r] <= 1'b0;
            end
        end
    end

    assign busy_vec = busy_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file with optional write-to-read bypass and busy scoreboard.
`ifndef STACK_ADDRESS
`define STACK_ADDRESS 32'h0000_8000
`endif

module regfile_mp
    import trv_regfile_pkg::*;
#(
    parameter int              XLEN      = 32,
    parameter int              REG_COUNT = REG_COUNT_RV32I,
    parameter int              N_RD      = 2,
    parameter int              N_WR      = 1,
    parameter int              BYPASS    = 1,
    parameter logic [XLEN-1:0] SP_INIT   = XLEN'(`STACK_ADDRESS),
    localparam int             AW        = $clog2(REG_COUNT)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_WR-1:0]           wr_en,
    input  logic [N_WR-1:0][AW-1:0]   wr_addr,
    input  logic [N_WR-1:0][XLEN-1:0] wr_data,
    input  logic [N_RD-1:0][AW-1:0]   rs_addr,
    output logic [N_RD-1:0][XLEN-1:0] rs_data,
    output logic [N_RD-1:0]           rs_busy,
    input  logic                      alloc_en,
    input  logic [AW-1:0]             alloc_addr,
    output logic [REG_COUNT-1:0]      busy_vec
);

    logic [XLEN-1:0] regs [REG_COUNT];

    // x0 and addresses past the end of the file behave as a constant-zero, never-busy register.
    function automatic logic addr_ok(logic [AW-1:0] a);
        return (a != AW'(REG_X0)) && (int'(a) < REG_COUNT);
    endfunction

    // Later ports overwrite earlier ones, giving the highest port index priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < REG_COUNT; r++) begin
                regs[r] <= (r == REG_SP) ? SP_INIT : '0;
            end
        end else begin
            for (int i = 0; i < N_WR; i++) begin
                if (wr_en[i] && addr_ok(wr_addr[i])) regs[wr_addr[i]] <= wr_data[i];
            end
        end
    end

    regfile_scoreboard #(
        .REG_COUNT (REG_COUNT),
        .N_WR      (N_WR),
        .AW        (AW)
    ) u_sb (
        .clk        (clk),
        .rst        (rst),
        .alloc_en   (alloc_en),
        .alloc_addr (alloc_addr),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .busy_vec   (busy_vec)
    );

    for (genvar j = 0; j < N_RD; j++) begin : g_rd
        logic            hit;
        logic [XLEN-1:0] byp;
        logic [XLEN-1:0] data;
        logic            busy;

        always_comb begin
            hit  = 1'b0;
            byp  = '0;
            data = '0;
            busy = 1'b0;
            for (int i = 0; i < N_WR; i++) begin
                if (BYPASS != 0 && wr_en[i] && wr_addr[i] == rs_addr[j]) begin
                    hit = 1'b1;
                    byp = wr_data[i];
                end
            end
            if (addr_ok(rs_addr[j])) begin
                data = hit ? byp : regs[rs_addr[j]];
                busy = busy_vec[rs_addr[j]] & ~hit;
            end
        end

        assign rs_data[j] = data;
        assign rs_busy[j] = busy;
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Randomized check of regfile_mp (bypass and non-bypass builds) against a behavioural model.
module tb_regfile_mp;

    localparam logic [31:0] SP = 32'h0001_0000;

    logic             clk = 1'b0;
    logic             rst;
    logic [1:0]       wr_en;
    logic [1:0][4:0]  wr_addr;
    logic [1:0][31:0] wr_data;
    logic [1:0][4:0]  rs_addr;
    logic             alloc_en;
    logic [4:0]       alloc_addr;

    logic [1:0][31:0] rs_data_b1, rs_data_b0;
    logic [1:0]       rs_busy_b1, rs_busy_b0;
    logic [31:0]      busy_vec_b1, busy_vec_b0;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] mem [32];
    logic [31:0] sb;

    always #5 clk = ~clk;

    regfile_mp #(.XLEN(32), .REG_COUNT(32), .N_RD(2), .N_WR(2), .BYPASS(1), .SP_INIT(SP)) dut_b1 (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rs_addr(rs_addr), .rs_data(rs_data_b1), .rs_busy(rs_busy_b1),
        .alloc_en(alloc_en), .alloc_addr(alloc_addr), .busy_vec(busy_vec_b1)
    );

    regfile_mp #(.XLEN(32), .REG_COUNT(32), .N_RD(2), .N_WR(2), .BYPASS(0), .SP_INIT(SP)) dut_b0 (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rs_addr(rs_addr), .rs_data(rs_data_b0), .rs_busy(rs_busy_b0),
        .alloc_en(alloc_en), .alloc_addr(alloc_addr), .busy_vec(busy_vec_b0)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_data(input bit byp, input logic [4:0] a);
        logic [31:0] d;
        if (a == 5'd0) return 32'd0;
        d = mem[a];
        if (byp)
            for (int i = 0; i < 2; i++)
                if (wr_en[i] && wr_addr[i] == a) d = wr_data[i];
        return d;
    endfunction

    function automatic logic exp_busy(input bit byp, input logic [4:0] a);
        bit h = 0;
        if (a == 5'd0) return 1'b0;
        for (int i = 0; i < 2; i++)
            if (byp && wr_en[i] && wr_addr[i] == a) h = 1;
        return sb[a] & ~h;
    endfunction

    // Architectural effect of one clock: writes land in port order, writebacks retire, alloc re-arms.
    task automatic model_clock();
        logic [31:0] nsb;
        if (rst) begin
            for (int r = 0; r < 32; r++) mem[r] = (r == 2) ? SP : 32'd0;
            sb = '0;
        end else begin
            nsb = sb;
            for (int i = 0; i < 2; i++) begin
                if (wr_en[i] && wr_addr[i] != 5'd0) begin
                    mem[wr_addr[i]] = wr_data[i];
                    nsb[wr_addr[i]] = 1'b0;
                end
            end
            if (alloc_en && alloc_addr != 5'd0) nsb[alloc_addr] = 1'b1;
            sb = nsb;
        end
    endtask

    task automatic check_all();
        for (int j = 0; j < 2; j++) begin
            chk($sformatf("b1_data%0d", j), rs_data_b1[j], exp_data(1, rs_addr[j]));
            chk($sformatf("b0_data%0d", j), rs_data_b0[j], exp_data(0, rs_addr[j]));
        end
        chk("b1_busy", {30'd0, rs_busy_b1}, {30'd0, exp_busy(1, rs_addr[1]), exp_busy(1, rs_addr[0])});
        chk("b0_busy", {30'd0, rs_busy_b0}, {30'd0, exp_busy(0, rs_addr[1]), exp_busy(0, rs_addr[0])});
        chk("b1_busy_vec", busy_vec_b1, sb);
        chk("b0_busy_vec", busy_vec_b0, sb);
    endtask

    task automatic step();
        @(negedge clk);
        check_all();
        @(posedge clk);
        model_clock();
        #1;
    endtask

    task automatic idle();
        rst = 0; wr_en = '0; wr_addr = '0; wr_data = '0;
        alloc_en = 0; alloc_addr = '0; rs_addr = '0;
    endtask

    initial begin
        idle();
        rst = 1;
        @(posedge clk);
        model_clock();
        #1;

        // Reset contents
        idle(); rs_addr[0] = 5'd2; rs_addr[1] = 5'd5; #1;
        chk("rst_x2", rs_data_b1[0], SP);
        chk("rst_x5", rs_data_b0[1], 32'd0);
        chk("rst_rs_busy", {30'd0, rs_busy_b1}, 32'd0);
        chk("rst_busy_vec", busy_vec_b0, 32'd0);
        step();

        // Plain write, then write to x0
        idle(); wr_en = 2'b01; wr_addr[0] = 5'd5; wr_data[0] = 32'hDEADBEEF; step();
        idle(); rs_addr[1] = 5'd5; #1;
        chk("wr_x5", rs_data_b0[1], 32'hDEADBEEF);
        idle(); wr_en = 2'b01; wr_addr[0] = 5'd0; wr_data[0] = 32'h1234; step();
        idle(); #1;
        chk("wr_x0_b1", rs_data_b1[0], 32'd0);
        chk("wr_x0_b0", rs_data_b0[0], 32'd0);

        // Same-cycle bypass
        idle(); wr_en = 2'b01; wr_addr[0] = 5'd7; wr_data[0] = 32'h11; step();
        idle(); wr_en = 2'b01; wr_addr[0] = 5'd7; wr_data[0] = 32'h22; rs_addr[0] = 5'd7; #1;
        chk("byp1_x7", rs_data_b1[0], 32'h22);
        chk("byp0_x7", rs_data_b0[0], 32'h11);
        step();
        idle(); rs_addr[0] = 5'd7; #1;
        chk("byp0_x7_next", rs_data_b0[0], 32'h22);

        // Write-port priority
        idle(); wr_en = 2'b11; wr_addr[0] = 5'd9; wr_addr[1] = 5'd9;
        wr_data[0] = 32'hA; wr_data[1] = 32'hB; rs_addr[0] = 5'd9; #1;
        chk("prio_byp", rs_data_b1[0], 32'hB);
        step();
        idle(); rs_addr[0] = 5'd9; #1;
        chk("prio_x9", rs_data_b0[0], 32'hB);

        // Scoreboard
        idle(); alloc_en = 1; alloc_addr = 5'd3; step();
        idle(); rs_addr[0] = 5'd3; #1;
        chk("sb_alloc_vec", {31'd0, busy_vec_b1[3]}, 32'd1);
        chk("sb_alloc_rs", {31'd0, rs_busy_b0[0]}, 32'd1);
        idle(); wr_en = 2'b01; wr_addr[0] = 5'd3; wr_data[0] = 32'h33; rs_addr[0] = 5'd3; #1;
        chk("sb_wb_byp1", {31'd0, rs_busy_b1[0]}, 32'd0);
        chk("sb_wb_byp0", {31'd0, rs_busy_b0[0]}, 32'd1);
        step();
        idle(); #1;
        chk("sb_cleared", {31'd0, busy_vec_b1[3]}, 32'd0);
        idle(); alloc_en = 1; alloc_addr = 5'd3; wr_en = 2'b01; wr_addr[0] = 5'd3; step();
        idle(); #1;
        chk("sb_alloc_wins", {31'd0, busy_vec_b0[3]}, 32'd1);

        // Reset mid-operation
        idle(); wr_en = 2'b01; wr_addr[0] = 5'd2; wr_data[0] = 32'h100; step();
        idle(); rst = 1; wr_en = 2'b01; wr_addr[0] = 5'd4; wr_data[0] = 32'h55;
        alloc_en = 1; alloc_addr = 5'd6; step();
        idle(); rs_addr[0] = 5'd2; rs_addr[1] = 5'd4; #1;
        chk("mid_rst_x2", rs_data_b1[0], SP);
        chk("mid_rst_x4", rs_data_b0[1], 32'd0);
        chk("mid_rst_busy", busy_vec_b1, 32'd0);

        // Random traffic, narrow address range to force collisions
        for (int n = 0; n < 400; n++) begin
            rst        = ($urandom_range(0, 49) == 0);
            wr_en      = 2'($urandom_range(0, 3));
            wr_addr[0] = 5'($urandom_range(0, 11));
            wr_addr[1] = 5'($urandom_range(0, 11));
            wr_data[0] = $urandom;
            wr_data[1] = $urandom;
            alloc_en   = ($urandom_range(0, 2) == 0);
            alloc_addr = 5'($urandom_range(0, 11));
            rs_addr[0] = 5'($urandom_range(0, 11));
            rs_addr[1] = 5'($urandom_range(0, 31));
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
